// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Instruction-fetch sequencer for a 2^AW-word combinational instruction ROM.
//   Owns the byte-addressed fetch PC, drives the ROM word address, and buffers
//   fetched words in a DEPTH-entry prefetch FIFO that feeds decode over a
//   valid/ready handshake. Supports start/stop sequencing and branch redirect
//   with flush.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        pulse, IDLE -> RUN (with redirect also loads the fetch PC)
//   stop         pulse, RUN -> DRAIN
//   redirect     branch taken / flush request from execute
//   redirect_pc  byte-address redirect target, low two bits ignored
//   imem_addr    ROM word address, fetch_pc[AW+1:2]
//   imem_q       ROM read data for imem_addr
//   if_valid     FIFO head holds a valid instruction
//   if_ready     decode accepts the head this cycle
//   if_instr     head instruction
//   if_pc        byte PC of the head instruction
//   busy         state is not IDLE
//
// Optional build macro IMEM_FETCH_PERF_EN adds saturating counters
//   fetch_count  pushes into the FIFO
//   stall_count  RUN cycles with a full FIFO and no accept
//   flush_count  redirects that discarded at least one valid entry

module imem_fetch_ctrl #(
   parameter int             N        = 64,
   parameter int             AW       = 6,
   parameter int             DEPTH    = 2,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          redirect,
   input  logic [N-1:0]  redirect_pc,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_q,
   output logic          if_valid,
   input  logic          if_ready,
   output logic [31:0]   if_instr,
   output logic [N-1:0]  if_pc,
   output logic          busy
`ifdef IMEM_FETCH_PERF_EN
   ,
   output logic [N-1:0]  fetch_count,
   output logic [N-1:0]  stall_count,
   output logic [N-1:0]  flush_count
`endif
);

   // state | meaning
   // IDLE  | no fetch, waiting for start
   // RUN   | fetch one word per cycle while the FIFO has room
   // DRAIN | no fetch, decode empties the FIFO, then IDLE
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t         state;
   logic [N-1:0]   fetch_pc;
   logic [N-1:0]   pc_mem    [DEPTH];
   logic [31:0]    instr_mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count;

   logic           flush;
   logic           accept;
   logic           pop;
   logic           push;
   logic [N-1:0]   redirect_target;

   assign imem_addr       = fetch_pc[AW+1:2];
   assign if_valid        = (count != '0);
   assign if_instr        = instr_mem[rd_ptr];
   assign if_pc           = pc_mem[rd_ptr];
   assign busy            = (state != S_IDLE);
   assign redirect_target = redirect_pc & ~N'(3);

   // A redirect outside IDLE wins over everything: the head being accepted
   // in the same cycle is discarded rather than counted as a pop.
   assign flush  = redirect && (state != S_IDLE);
   assign accept = if_valid && if_ready;
   assign pop    = accept && !flush;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push   = (state == S_RUN) && !redirect && !stop &&
                   ((count != FULL) || accept);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               pc_mem[wr_ptr]    <= fetch_pc;
               instr_mem[wr_ptr] <= imem_q;
               wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
               count <= count + CW'(1);
            end else if (pop && !push) begin
               count <= count - CW'(1);
            end
         end

         if (flush || ((state == S_IDLE) && start && redirect)) begin
            fetch_pc <= redirect_target;
         end else if (push) begin
            fetch_pc <= fetch_pc + N'(4);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (stop) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (redirect || (count == '0) || ((count == CW'(1)) && pop)) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef IMEM_FETCH_PERF_EN
   logic stall;
   logic flush_hit;

   assign stall     = (state == S_RUN) && (count == FULL) && !accept;
   assign flush_hit = flush && if_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (push && (fetch_count != '1)) begin
            fetch_count <= fetch_count + N'(1);
         end
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + N'(1);
         end
         if (flush_hit && (flush_count != '1)) begin
            flush_count <= flush_count + N'(1);
         end
      end
   end
`endif

endmodule
